// File: rtl/spi_slave_sync.sv
// SPI slave front end: filters the async sck/ncs/mosi pins into the clk domain
// and moves whole WORD_W-bit words in any of the four SPI modes.
module spi_slave_sync #(
  parameter int WORD_W    = 8,
  parameter int FILT_LEN  = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ncs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_req,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              spi_start,
  output logic              frame_err,
  output logic              spi_busy
);
  localparam int CW = $clog2(WORD_W);

  logic [FILT_LEN-1:0] sck_sh, ncs_sh, mosi_sh, settle;
  logic                sck_q, sck_d, ncs_q, ncs_d;
  logic                armed, hold;
  logic [CW-1:0]       bit_cnt;
  logic [WORD_W-1:0]   rx_sh, tx_sh, rx_nxt;
  logic                sck_chg, lead, trail, live, smp, shf, start, stop, last, mosi_al;

  // Pin filters with hysteresis; settle marks when the filters hold only real
  // post-reset pin samples, so a reset mid-frame cannot arm on stale ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sh  <= {FILT_LEN{CPOL}};
      ncs_sh  <= '1;
      mosi_sh <= '0;
      settle  <= '0;
      sck_q   <= CPOL;
      sck_d   <= CPOL;
      ncs_q   <= 1'b1;
      ncs_d   <= 1'b1;
    end else begin
      sck_sh  <= {sck_sh[FILT_LEN-2:0], sck};
      ncs_sh  <= {ncs_sh[FILT_LEN-2:0], ncs};
      mosi_sh <= {mosi_sh[FILT_LEN-2:0], mosi};
      settle  <= {settle[FILT_LEN-2:0], 1'b1};
      if (&sck_sh)       sck_q <= 1'b1;
      else if (~|sck_sh) sck_q <= 1'b0;
      if (&ncs_sh)       ncs_q <= 1'b1;
      else if (~|ncs_sh) ncs_q <= 1'b0;
      sck_d <= sck_q;
      ncs_d <= ncs_q;
    end
  end

  always_comb begin
    sck_chg = sck_q ^ sck_d;
    lead    = sck_chg & (sck_q != CPOL);
    trail   = sck_chg & (sck_q == CPOL);
    live    = armed & ~ncs_q;
    smp     = live & (CPHA ? trail : lead);
    shf     = live & (CPHA ? lead : trail);
    start   = armed & ncs_d & ~ncs_q;
    stop    = ~ncs_d & ncs_q;
    last    = (bit_cnt == CW'(WORD_W-1));
    mosi_al = mosi_sh[FILT_LEN-1];
    rx_nxt  = MSB_FIRST ? {rx_sh[WORD_W-2:0], mosi_al} : {mosi_al, rx_sh[WORD_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      hold      <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      spi_start <= 1'b0;
      frame_err <= 1'b0;
      spi_busy  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      spi_start <= 1'b0;
      frame_err <= 1'b0;
      if (settle[FILT_LEN-1] && ncs_q && (&ncs_sh)) armed <= 1'b1;
      if (start) begin
        bit_cnt   <= '0;
        tx_sh     <= tx_data;
        tx_req    <= 1'b1;
        hold      <= CPHA;
        spi_start <= 1'b1;
        spi_busy  <= 1'b1;
      end else if (smp) begin
        rx_sh <= rx_nxt;
        if (last) begin
          rx_data  <= rx_nxt;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
          tx_sh    <= tx_data;
          tx_req   <= 1'b1;
          hold     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (shf) begin
        // hold swallows the shift edge that would skip a freshly loaded bit
        if (hold) hold <= 1'b0;
        else tx_sh <= MSB_FIRST ? {tx_sh[WORD_W-2:0], 1'b0} : {1'b0, tx_sh[WORD_W-1:1]};
      end
      if (stop && bit_cnt != '0) begin
        frame_err <= 1'b1;
        bit_cnt   <= '0;
      end
      if (!start && ncs_q && sck_q == CPOL) spi_busy <= 1'b0;
    end
  end

  assign miso    = MSB_FIRST ? tx_sh[WORD_W-1] : tx_sh[0];
  assign miso_oe = armed & ~ncs_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: three configurations driven by one SPI master model,
// received words checked through a scoreboard, miso words checked per frame.
module tb_spi_slave_sync;
  localparam int H = 6;
  localparam bit [2:0] CPOL_V = 3'b010;
  localparam bit [2:0] CPHA_V = 3'b110;
  localparam bit [2:0] MSB_V  = 3'b011;
  localparam int W_V [3] = '{8, 8, 12};

  logic clk, rst;
  logic m_sck, m_ncs, m_mosi;
  int   sel;
  logic [2:0] sck_p, ncs_p, mosi_p, miso_v, oe_v, txreq_v, rxv_v, start_v, ferr_v, busy_v;
  logic [7:0]  rx0, rx1, tx0, tx1;
  logic [11:0] rx2, tx2;
  logic [31:0] rxd [3];
  logic [31:0] tx_cur [3], tx_next [3], txsel [3];
  int swap_at [3];
  int n_start [3], n_txreq [3], n_rxv [3], n_ferr [3], n_oe [3];
  int n_cmp, n_bad;

  typedef struct {int inst; logic [31:0] val;} exp_t;
  exp_t sb[$];
  typedef struct {int inst; logic [31:0] mo; logic [31:0] tx; logic [31:0] exp_rx; logic [31:0] exp_mi;} vec_t;

  spi_slave_sync #(.WORD_W(8), .FILT_LEN(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .sck(sck_p[0]), .ncs(ncs_p[0]), .mosi(mosi_p[0]), .miso(miso_v[0]),
    .miso_oe(oe_v[0]), .tx_data(tx0), .tx_req(txreq_v[0]), .rx_data(rx0), .rx_valid(rxv_v[0]),
    .spi_start(start_v[0]), .frame_err(ferr_v[0]), .spi_busy(busy_v[0]));
  spi_slave_sync #(.WORD_W(8), .FILT_LEN(3), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .sck(sck_p[1]), .ncs(ncs_p[1]), .mosi(mosi_p[1]), .miso(miso_v[1]),
    .miso_oe(oe_v[1]), .tx_data(tx1), .tx_req(txreq_v[1]), .rx_data(rx1), .rx_valid(rxv_v[1]),
    .spi_start(start_v[1]), .frame_err(ferr_v[1]), .spi_busy(busy_v[1]));
  spi_slave_sync #(.WORD_W(12), .FILT_LEN(2), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .sck(sck_p[2]), .ncs(ncs_p[2]), .mosi(mosi_p[2]), .miso(miso_v[2]),
    .miso_oe(oe_v[2]), .tx_data(tx2), .tx_req(txreq_v[2]), .rx_data(rx2), .rx_valid(rxv_v[2]),
    .spi_start(start_v[2]), .frame_err(ferr_v[2]), .spi_busy(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // route the master to the selected slave, park the others idle
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sck_p[i]  = CPOL_V[i];
      ncs_p[i]  = 1'b1;
      mosi_p[i] = 1'b0;
      if (sel == i) begin
        sck_p[i]  = m_sck;
        ncs_p[i]  = m_ncs;
        mosi_p[i] = m_mosi;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) txsel[i] = (n_txreq[i] > swap_at[i]) ? tx_next[i] : tx_cur[i];
    tx0 = txsel[0][7:0];
    tx1 = txsel[1][7:0];
    tx2 = txsel[2][11:0];
    rxd[0] = 32'(rx0);
    rxd[1] = 32'(rx1);
    rxd[2] = 32'(rx2);
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (start_v[i]) n_start[i]++;
      if (txreq_v[i]) n_txreq[i]++;
      if (ferr_v[i])  n_ferr[i]++;
      if (oe_v[i])    n_oe[i]++;
      if (rxv_v[i]) begin
        n_rxv[i]++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_valid_unexpected: got word %0h on inst %0d expected none", rxd[i], i);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rx_inst", 32'(i), 32'(e.inst));
          check("rx_data", rxd[i], e.val);
        end
      end
    end
  end

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic sel_inst(input int i);
    m_ncs  = 1'b1;
    m_sck  = CPOL_V[i];
    m_mosi = 1'b0;
    sel    = i;
    repeat (4) @(negedge clk);
  endtask

  task automatic open_f();
    m_ncs = 1'b0;
    wait_h();
  endtask

  task automatic close_f();
    wait_h();
    m_ncs = 1'b1;
    repeat (3 * H) @(negedge clk);
  endtask

  task automatic xfer(input int i, input logic [31:0] mo, input int nbits, output logic [31:0] mi);
    int idx;
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      idx = MSB_V[i] ? W_V[i] - 1 - b : b;
      if (!CPHA_V[i]) begin
        m_mosi = mo[idx];
        wait_h();
        m_sck = ~CPOL_V[i];
        mi[idx] = miso_v[i];
        wait_h();
        m_sck = CPOL_V[i];
      end else begin
        m_sck  = ~CPOL_V[i];
        m_mosi = mo[idx];
        wait_h();
        m_sck = CPOL_V[i];
        mi[idx] = miso_v[i];
        wait_h();
      end
    end
  endtask

  initial begin
    vec_t vt [5];
    logic [31:0] mi, mi2;
    int s_st, s_tx, s_rx, s_fe, s_oe;
    vt[0] = '{0, 32'hA5,  32'h3C,  32'hA5,  32'h3C};
    vt[1] = '{0, 32'h00,  32'hFF,  32'h00,  32'hFF};
    vt[2] = '{0, 32'hFF,  32'h81,  32'hFF,  32'h81};
    vt[3] = '{2, 32'hABC, 32'h123, 32'hABC, 32'h123};
    vt[4] = '{2, 32'h5A5, 32'hF0F, 32'h5A5, 32'hF0F};
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 3; i++) begin
      tx_cur[i] = '0; tx_next[i] = '0; swap_at[i] = 0;
    end
    m_sck = 1'b0; m_ncs = 1'b1; m_mosi = 1'b0; sel = 0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rx_data", rxd[0], 32'h0);
    check("rst_strobes", 32'({rxv_v[0], txreq_v[0], start_v[0], ferr_v[0]}), 32'h0);
    check("rst_miso", 32'({miso_v[0], oe_v[0], busy_v[0]}), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // table-driven single-word frames
    for (int k = 0; k < 5; k++) begin
      sel_inst(vt[k].inst);
      tx_cur[vt[k].inst]  = vt[k].tx;
      tx_next[vt[k].inst] = vt[k].tx;
      s_st = n_start[vt[k].inst];
      s_tx = n_txreq[vt[k].inst];
      sb.push_back('{vt[k].inst, vt[k].exp_rx});
      open_f();
      xfer(vt[k].inst, vt[k].mo, W_V[vt[k].inst], mi);
      check("busy_mid", 32'(busy_v[vt[k].inst]), 32'h1);
      close_f();
      check("miso_word", mi, vt[k].exp_mi);
      check("rx_hold", rxd[vt[k].inst], vt[k].exp_rx);
      check("start_cnt", 32'(n_start[vt[k].inst] - s_st), 32'h1);
      check("tx_req_cnt", 32'(n_txreq[vt[k].inst] - s_tx), 32'h2);
      check("sb_drained", 32'(sb.size()), 32'h0);
      check("busy_end", 32'({busy_v[vt[k].inst], oe_v[vt[k].inst]}), 32'h0);
    end

    // glitches: 1-clk on FILT_LEN=2, 2-clk on FILT_LEN=3
    sel_inst(0);
    s_st = n_start[0]; s_tx = n_txreq[0]; s_oe = n_oe[0];
    m_sck = 1'b1; @(negedge clk); m_sck = 1'b0;
    repeat (3) @(negedge clk);
    m_ncs = 1'b0; @(negedge clk); m_ncs = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch0_start", 32'(n_start[0] - s_st), 32'h0);
    check("glitch0_act", 32'((n_txreq[0] - s_tx) + (n_oe[0] - s_oe)), 32'h0);
    check("glitch0_rx", rxd[0], 32'hFF);
    sel_inst(1);
    s_st = n_start[1]; s_oe = n_oe[1];
    m_sck = 1'b0; repeat (2) @(negedge clk); m_sck = 1'b1;
    repeat (3) @(negedge clk);
    m_ncs = 1'b0; repeat (2) @(negedge clk); m_ncs = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch1_start", 32'(n_start[1] - s_st), 32'h0);
    check("glitch1_oe", 32'(n_oe[1] - s_oe), 32'h0);

    // mode 3, back-to-back words, tx_data swapped on the first tx_req
    tx_cur[1] = 32'h81; tx_next[1] = 32'h7E; swap_at[1] = n_txreq[1];
    s_tx = n_txreq[1]; s_rx = n_rxv[1];
    sb.push_back('{1, 32'h12});
    sb.push_back('{1, 32'hF0});
    open_f();
    xfer(1, 32'h12, 8, mi);
    check("m3_busy_gap", 32'(busy_v[1]), 32'h1);
    xfer(1, 32'hF0, 8, mi2);
    close_f();
    check("m3_miso0", mi, 32'h81);
    check("m3_miso1", mi2, 32'h7E);
    check("m3_tx_req_cnt", 32'(n_txreq[1] - s_tx), 32'h3);
    check("m3_rx_cnt", 32'(n_rxv[1] - s_rx), 32'h2);

    // abort after 5 bits, then a clean frame
    sel_inst(0);
    tx_cur[0] = 32'h00; tx_next[0] = 32'h00;
    s_fe = n_ferr[0]; s_rx = n_rxv[0];
    open_f();
    xfer(0, 32'h0F, 5, mi);
    close_f();
    check("abort_ferr", 32'(n_ferr[0] - s_fe), 32'h1);
    check("abort_no_rx", 32'(n_rxv[0] - s_rx), 32'h0);
    check("abort_busy", 32'(busy_v[0]), 32'h0);
    sb.push_back('{0, 32'h55});
    open_f();
    xfer(0, 32'h55, 8, mi);
    close_f();
    check("after_abort_rx", rxd[0], 32'h55);
    check("after_abort_ferr", 32'(n_ferr[0] - s_fe), 32'h1);

    // reset mid-frame with ncs held low
    open_f();
    xfer(0, 32'hC3, 3, mi);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rx", rxd[0], 32'h0);
    check("midrst_out", 32'({miso_v[0], oe_v[0], busy_v[0], rxv_v[0], txreq_v[0]}), 32'h0);
    s_st = n_start[0]; s_tx = n_txreq[0]; s_oe = n_oe[0]; s_rx = n_rxv[0];
    xfer(0, 32'hC3, 5, mi);
    close_f();
    check("midrst_quiet", 32'((n_start[0] - s_st) + (n_txreq[0] - s_tx) + (n_rxv[0] - s_rx)), 32'h0);
    check("midrst_oe", 32'(n_oe[0] - s_oe), 32'h0);
    sb.push_back('{0, 32'hC3});
    open_f();
    xfer(0, 32'hC3, 8, mi);
    close_f();
    check("rearm_start", 32'(n_start[0] - s_st), 32'h1);
    check("rearm_rx", rxd[0], 32'hC3);
    check("final_sb", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
